// File: rtl/frame_cmd_gen.sv
// Command-frame generator: header, payload words from a host-written template RAM,
// then a modular checksum, streamed over valid/ready with no bubbles at full rate.
//
// state  | meaning
// S_IDLE | no frame in flight, config writes accepted
// S_HDR  | presenting the header word
// S_PAY  | presenting payload words 1..L
// S_CSUM | presenting the checksum word (frame_last)
// S_GAP  | enforced idle time before the next frame may start
module frame_cmd_gen #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 10,
    parameter int                LEN_DEF = 181,
    parameter logic [DATA_W-1:0] HEADER  = 16'hABCD,
    parameter int                GAP_CYC = 20
) (
    input  logic              clk,
    input  logic              FPGA_RESET,
    input  logic [7:0]        FPGA_MOD,
    input  logic              tx_start,
    input  logic              auto_en,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_din,
    input  logic              cfg_len_we,
    input  logic [ADDR_W:0]   cfg_len,
    output logic [DATA_W-1:0] frame_out,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_last,
    output logic [ADDR_W:0]   fiber_addrb,
    output logic              busy,
    output logic              cfg_err
);

    localparam int              LEN_MAX_I  = 2**ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX    = LEN_MAX_I[ADDR_W:0];
    localparam logic [ADDR_W:0] LEN_RST    = LEN_DEF[ADDR_W:0];
    localparam int              GAP_LOAD_I = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
    localparam logic [7:0]      GAP_LOAD   = GAP_LOAD_I[7:0];

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CSUM, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] q, sum;
    logic [ADDR_W:0]   len_reg, len_frame, len_start, idx, idx_nxt;
    logic [7:0]        gap_cnt, mod_shadow;
    logic              pending, rst_d;
    logic              trig, xfer, gap_done, start_frame, len_ok, len_wr_ok;

    assign trig        = tx_start || (FPGA_MOD != mod_shadow) || (rst_d && auto_en);
    assign xfer        = frame_valid && frame_ready;
    assign gap_done    = (state == S_GAP) && (gap_cnt == 8'd0);
    assign len_ok      = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign len_wr_ok   = cfg_len_we && !busy && len_ok;
    // A length written in the trigger cycle already applies to that frame.
    assign len_start   = len_wr_ok ? cfg_len : len_reg;
    assign start_frame = (state_nxt == S_HDR) && (state != S_HDR);
    assign fiber_addrb = idx;

    always_ff @(posedge clk) begin
        if (FPGA_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (trig) state_nxt = S_HDR;
            S_HDR:  if (xfer) state_nxt = S_PAY;
            S_PAY:  if (xfer && (idx == len_frame)) state_nxt = S_CSUM;
            S_CSUM: if (xfer) state_nxt = S_GAP;
            S_GAP:  if (gap_cnt == 8'd0) state_nxt = (pending || trig) ? S_HDR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        frame_valid = 1'b0;
        frame_last  = 1'b0;
        frame_out   = '0;
        busy        = (state != S_IDLE);
        case (state)
            S_HDR: begin
                frame_valid = 1'b1;
                frame_out   = HEADER;
            end
            S_PAY: begin
                frame_valid = 1'b1;
                frame_out   = q;
            end
            S_CSUM: begin
                frame_valid = 1'b1;
                frame_last  = 1'b1;
                frame_out   = sum;
            end
            default: ;
        endcase
    end

    // Index of the word shown after the next edge; the RAM is read one word ahead
    // of it so q always holds the payload word currently on frame_out.
    always_comb begin
        idx_nxt = idx;
        if ((state == S_IDLE) || (state == S_GAP)) begin
            idx_nxt = '0;
        end else if (xfer) begin
            idx_nxt = (state == S_CSUM) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (FPGA_RESET) begin
            len_reg    <= LEN_RST;
            len_frame  <= LEN_RST;
            pending    <= 1'b0;
            mod_shadow <= FPGA_MOD;
            rst_d      <= 1'b1;
            cfg_err    <= 1'b0;
            idx        <= '0;
            gap_cnt    <= '0;
            sum        <= '0;
        end else begin
            mod_shadow <= FPGA_MOD;
            rst_d      <= 1'b0;
            idx        <= idx_nxt;
            cfg_err    <= ((cfg_we || cfg_len_we) && busy) || (cfg_len_we && !busy && !len_ok);
            if (len_wr_ok) len_reg <= cfg_len;
            if (gap_done) begin
                pending <= 1'b0;
            end else if (trig && busy) begin
                pending <= 1'b1;
            end
            if (start_frame) begin
                len_frame <= len_start;
                sum       <= HEADER;
            end else if ((state == S_PAY) && xfer) begin
                sum <= sum + q;
            end
            if ((state == S_CSUM) && xfer) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Template RAM survives reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) ram[cfg_addr] <= cfg_din;
        q <= ram[ADDR_W'(idx_nxt - 1'b1)];
    end

endmodule

// File: tb/tb_frame_cmd_gen.sv
// Bench for frame_cmd_gen: a monitor captures every stream transfer and each
// scenario task compares the capture with frames built from a template model.
module tb_frame_cmd_gen;

    localparam int          DATA_W  = 16;
    localparam int          ADDR_W  = 10;
    localparam int          LEN_DEF = 181;
    localparam int          GAP_CYC = 20;
    localparam logic [15:0] HEADER  = 16'hABCD;

    logic        clk = 1'b0;
    logic        FPGA_RESET = 1'b1;
    logic [7:0]  FPGA_MOD = 8'h01;
    logic        tx_start = 1'b0, auto_en = 1'b0, cfg_we = 1'b0, cfg_len_we = 1'b0;
    logic [9:0]  cfg_addr = '0;
    logic [15:0] cfg_din = '0;
    logic [10:0] cfg_len = '0;
    logic [15:0] frame_out;
    logic        frame_valid, frame_last, busy, cfg_err;
    logic        frame_ready = 1'b1;
    logic [10:0] fiber_addrb;

    frame_cmd_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_DEF(LEN_DEF),
                    .HEADER(HEADER), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .FPGA_RESET(FPGA_RESET), .FPGA_MOD(FPGA_MOD), .tx_start(tx_start),
        .auto_en(auto_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_last(frame_last),
        .fiber_addrb(fiber_addrb), .busy(busy), .cfg_err(cfg_err));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, stall_viol = 0, err_pulses = 0, ready_mode = 0, rpat = 0;
    logic [15:0] cap_data[$];
    logic        cap_last[$];
    logic [10:0] cap_addr[$];
    int          cap_cyc[$];
    logic [15:0] mram [1024];
    int          mlen = LEN_DEF;
    logic [15:0] exp_q[$];

    initial begin : monitor
        logic p_valid, p_ready, p_last;
        logic [15:0] p_out;
        logic [10:0] p_addr;
        p_valid = 1'b0; p_ready = 1'b1; p_last = 1'b0; p_out = '0; p_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
                cap_data.push_back(frame_out);
                cap_last.push_back(frame_last);
                cap_addr.push_back(fiber_addrb);
                cap_cyc.push_back(cyc);
            end
            if (p_valid === 1'b1 && p_ready === 1'b0 && FPGA_RESET === 1'b0 &&
                (frame_valid !== 1'b1 || frame_out !== p_out || fiber_addrb !== p_addr ||
                 frame_last !== p_last))
                stall_viol++;
            if (cfg_err === 1'b1) err_pulses++;
            p_valid = frame_valid; p_ready = frame_ready; p_last = frame_last;
            p_out = frame_out; p_addr = fiber_addrb;
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: frame_ready = ($urandom_range(0, 1) == 1);
                2: begin
                    frame_ready = (rpat == 0);
                    rpat = (rpat + 1) % 3;
                end
                default: frame_ready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_data.delete(); cap_last.delete(); cap_addr.delete(); cap_cyc.delete();
    endtask

    task automatic cfg_write(input logic [9:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
        tick();
        cfg_we = 1'b0;
        mram[a] = d;
    endtask

    task automatic set_len(input int l);
        cfg_len_we = 1'b1; cfg_len = 11'(l);
        tick();
        cfg_len_we = 1'b0;
        mlen = l;
    endtask

    task automatic pulse_start();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && cap_data.size() < n; k++) tick();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy !== 1'b0; k++) tick();
    endtask

    // Expected frame: header, template words 0..L-1, then their sum mod 2**16.
    function automatic void build_expected();
        logic [15:0] s;
        exp_q.delete();
        s = HEADER;
        exp_q.push_back(HEADER);
        for (int i = 0; i < mlen; i++) begin
            exp_q.push_back(mram[i]);
            s = s + mram[i];
        end
        exp_q.push_back(s);
    endfunction

    // Index of the first captured word differing from exp_q, or -1 when all match.
    function automatic int frame_diff();
        int n;
        n = (cap_data.size() < exp_q.size()) ? cap_data.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cap_data[i] !== exp_q[i] || cap_last[i] !== (i == exp_q.size() - 1) ||
                cap_addr[i] !== 11'(i))
                return i;
        if (cap_data.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [15:0] cap_at(input int i);
        if (i >= 0 && i < cap_data.size()) return cap_data[i];
        return 16'h0;
    endfunction

    function automatic logic [15:0] exp_at(input int i);
        if (i >= 0 && i < exp_q.size()) return exp_q[i];
        return 16'h0;
    endfunction

    task automatic test_reset();
        FPGA_RESET = 1'b1; auto_en = 1'b0; ready_mode = 0;
        repeat (3) tick();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b required 0", cfg_err); end
        checks++; if (frame_out !== 16'h0) begin errors++; $display("FAIL reset_out: got %h required 0000", frame_out); end
        checks++; if (frame_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", frame_last); end
        checks++; if (fiber_addrb !== 11'd0) begin errors++; $display("FAIL reset_addrb: got %0d required 0", fiber_addrb); end
        FPGA_RESET = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_auto: busy got %b required 0", busy); end
        mlen = LEN_DEF;
    endtask

    task automatic test_basic();
        int d;
        for (int i = 0; i < 3; i++) cfg_write(10'(i), 16'(i + 1));
        set_len(3);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL basic_cfg_ok: cfg_err got %b required 0", cfg_err); end
        clear_cap();
        pulse_start();
        checks++;
        if (frame_valid !== 1'b1 || frame_out !== HEADER || fiber_addrb !== 11'd0) begin
            errors++;
            $display("FAIL basic_latency: got valid %b data %h addr %0d required 1 %h 0", frame_valid, frame_out, fiber_addrb, HEADER);
        end
        wait_words(5, 50);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL basic_frame: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        checks++;
        if (cap_cyc.size() != 5 || cap_cyc[4] - cap_cyc[0] != 4) begin
            errors++;
            $display("FAIL basic_back_to_back: got span %0d required 4", (cap_cyc.size() == 5) ? cap_cyc[4] - cap_cyc[0] : -1);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_gap: got %b required 1", busy); end
        wait_idle(100);
    endtask

    task automatic test_backpressure();
        int d;
        clear_cap();
        stall_viol = 0;
        rpat = 0;
        ready_mode = 2;
        pulse_start();
        wait_words(5, 100);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL bp_frame: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_viol); end
        ready_mode = 0;
        wait_idle(100);
    endtask

    task automatic test_mod_pending();
        int d;
        clear_cap();
        FPGA_MOD = 8'h02;
        tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_out !== HEADER) begin
            errors++;
            $display("FAIL mod_trigger: got valid %b data %h required 1 %h", frame_valid, frame_out, HEADER);
        end
        pulse_start();
        tick();
        pulse_start();
        wait_words(5, 50);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL mod_frame: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        wait_words(10, 100);
        checks++;
        if (cap_cyc.size() < 6 || cap_cyc[5] - cap_cyc[4] - 1 != GAP_CYC) begin
            errors++;
            $display("FAIL mod_gap: got %0d idle cycles required %0d", (cap_cyc.size() >= 6) ? cap_cyc[5] - cap_cyc[4] - 1 : -1, GAP_CYC);
        end
        for (int i = 0; i < 5 && cap_data.size() > 0; i++) begin
            void'(cap_data.pop_front()); void'(cap_last.pop_front());
            void'(cap_addr.pop_front()); void'(cap_cyc.pop_front());
        end
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL pending_frame: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        wait_idle(100);
        repeat (30) tick();
        checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL pending_single: got %0d words required 5", cap_data.size()); end
    endtask

    task automatic test_cfg_err();
        int d;
        err_pulses = 0;
        cfg_len_we = 1'b1; cfg_len = 11'd0;
        tick();
        cfg_len_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_len0: got %b required 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b required 0", cfg_err); end
        cfg_len_we = 1'b1; cfg_len = 11'd1025;
        tick();
        cfg_len_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_len1025: got %b required 1", cfg_err); end
        clear_cap();
        pulse_start();
        cfg_we = 1'b1; cfg_addr = 10'd1; cfg_din = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_busy_we: got %b required 1", cfg_err); end
        wait_words(5, 50);
        wait_idle(100);
        checks++; if (err_pulses != 3) begin errors++; $display("FAIL cfg_err_count: got %0d pulses required 3", err_pulses); end
        clear_cap();
        pulse_start();
        wait_words(5, 50);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL cfg_err_unchanged: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        wait_idle(100);
    endtask

    task automatic test_random();
        int d, lens[6];
        logic [15:0] nv;
        lens[0] = 1; lens[1] = 1024;
        for (int i = 2; i < 6; i++) lens[i] = $urandom_range(2, 40);
        for (int a = 0; a < 1024; a++) cfg_write(10'(a), 16'($urandom()));
        err_pulses = 0;
        stall_viol = 0;
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            wait_idle(200);
            clear_cap();
            if (f % 2 == 0) set_len(lens[f]);
            nv = 16'($urandom());
            cfg_we = 1'b1; cfg_addr = 10'd0; cfg_din = nv; tx_start = 1'b1;
            if (f % 2 == 1) begin cfg_len_we = 1'b1; cfg_len = 11'(lens[f]); end
            tick();
            cfg_we = 1'b0; tx_start = 1'b0; cfg_len_we = 1'b0;
            mram[0] = nv;
            mlen = lens[f];
            wait_words(mlen + 2, (mlen + 2) * 30 + 20);
            build_expected();
            d = frame_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL random_frame%0d len %0d: word %0d got %0d words data %h required %0d words data %h", f, mlen, d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
            end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL random_stable: got %0d unstable stalls required 0", stall_viol); end
        checks++; if (err_pulses != 0) begin errors++; $display("FAIL random_cfg_err: got %0d pulses required 0", err_pulses); end
        ready_mode = 0;
        wait_idle(200);
    endtask

    task automatic test_auto();
        int d;
        FPGA_RESET = 1'b1; auto_en = 1'b1;
        repeat (2) tick();
        clear_cap();
        FPGA_RESET = 1'b0;
        tick();
        checks++;
        if (frame_valid !== 1'b1 || frame_out !== HEADER) begin
            errors++;
            $display("FAIL auto_start: got valid %b data %h required 1 %h", frame_valid, frame_out, HEADER);
        end
        mlen = LEN_DEF;
        wait_words(LEN_DEF + 2, 400);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL auto_frame: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        wait_idle(100);
        repeat (30) tick();
        checks++; if (cap_data.size() != LEN_DEF + 2) begin errors++; $display("FAIL auto_once: got %0d words required %0d", cap_data.size(), LEN_DEF + 2); end
        auto_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        int d;
        set_len(3);
        pulse_start();
        pulse_start();
        tick();
        checks++; if (fiber_addrb !== 11'd2) begin errors++; $display("FAIL abort_setup: addrb got %0d required 2", fiber_addrb); end
        FPGA_RESET = 1'b1;
        tick();
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || frame_last !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got valid %b busy %b last %b required 0 0 0", frame_valid, busy, frame_last);
        end
        FPGA_RESET = 1'b0;
        mlen = LEN_DEF;
        clear_cap();
        repeat (40) tick();
        checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL abort_no_pending: got %0d words required 0", cap_data.size()); end
        pulse_start();
        wait_words(LEN_DEF + 2, 400);
        build_expected();
        d = frame_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL abort_ram_kept: word %0d got %0d words data %h required %0d words data %h", d, cap_data.size(), cap_at(d), exp_q.size(), exp_at(d));
        end
        wait_idle(100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mod_pending();
        test_cfg_err();
        test_random();
        test_auto();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
